// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scan states and matrix position map for the keypad scanner
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic [3:0] {
    KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3, KEY_4 = 4'd4,
    KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7, KEY_8 = 4'd8, KEY_9 = 4'd9,
    KEY_START = 4'd10, KEY_STOP = 4'd11, KEY_CLEAR = 4'd12, KEY_NONE = 4'd15
  } key_t;
  typedef enum logic [1:0] {SCAN_R0, SCAN_R1, SCAN_R2, SCAN_R3} scan_t;
  // Indexed by row*NUM_COLS + col; KEY_NONE marks unused positions
  localparam key_t KEY_MAP [NUM_ROWS*NUM_COLS] = '{
    KEY_1, KEY_2, KEY_3, KEY_START,
    KEY_4, KEY_5, KEY_6, KEY_STOP,
    KEY_7, KEY_8, KEY_9, KEY_CLEAR,
    KEY_NONE, KEY_0, KEY_NONE, KEY_NONE
  };
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a candidate key once it repeats for DEBOUNCE_PASSES passes
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_PASSES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic pass_done,
  input  key_t candidate,
  output key_t accepted
);
  localparam int CW = $clog2(DEBOUNCE_PASSES + 1);
  localparam logic [CW-1:0] MAXC = CW'(DEBOUNCE_PASSES);
  key_t previous;
  logic [CW-1:0] stable, stable_nxt;
  always_comb stable_nxt = (candidate != previous) ? CW'(1) : (stable == MAXC) ? MAXC : stable + 1'b1;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      previous <= KEY_NONE;
      stable <= '0;
      accepted <= KEY_NONE;
    end else if (pass_done) begin
      previous <= candidate;
      stable <= stable_nxt;
      if (stable_nxt == MAXC) accepted <= candidate;
    end
  end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 key matrix and drives debounced per-key levels
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_PASSES = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);
  logic [3:0] col_m, col_s;
  scan_t state;
  logic [1:0] nxt_row;
  logic [SW-1:0] cnt;
  logic run, pass_done, found, multi;
  logic [NUM_ROWS*NUM_COLS-1:0] pass;
  key_t candidate, code, accepted;
  assign nxt_row = state + 2'd1;
  always_comb begin
    found = 1'b0;
    multi = 1'b0;
    code = KEY_NONE;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++)
      if (pass[i] && KEY_MAP[i] != KEY_NONE) begin
        multi = multi | found;
        found = 1'b1;
        code = KEY_MAP[i];
      end
    candidate = (found && !multi) ? code : KEY_NONE;
  end
  // run holds off the scan for one edge so row 0 gets a full settle window after reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      state <= SCAN_R0;
      cnt <= '0;
      run <= 1'b0;
      row_n <= 4'hF;
      pass <= '0;
      pass_done <= 1'b0;
      keypad <= '0;
      startn <= 1'b1;
      stopn <= 1'b1;
      clearn <= 1'b1;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
      pass_done <= 1'b0;
      if (!run) begin
        run <= 1'b1;
        row_n <= 4'b1110;
      end else if (cnt == LAST) begin
        pass[{state, 2'b00} +: 4] <= ~col_s;
        pass_done <= state == SCAN_R3;
        state <= scan_t'(nxt_row);
        cnt <= '0;
        row_n <= 4'hF ^ (4'b0001 << nxt_row);
      end else cnt <= cnt + 1'b1;
      keypad <= (accepted <= KEY_9) ? 10'd1 << accepted : 10'd0;
      startn <= accepted != KEY_START;
      stopn <= accepted != KEY_STOP;
      clearn <= accepted != KEY_CLEAR;
    end
  end
  keypad_debounce #(.DEBOUNCE_PASSES(DEBOUNCE_PASSES)) u_debounce (
    .clock(clock),
    .resetn(resetn),
    .pass_done(pass_done),
    .candidate(candidate),
    .accepted(accepted)
  );
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench with a behavioural key matrix model
module tb_keypad_matrix_scanner;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] col_n, row_n;
  logic [9:0] keypad;
  logic startn, stopn, clearn;
  logic [15:0] held = '0;
  logic [12:0] out;
  int total = 0;
  int bad = 0;
  localparam logic [12:0] IDLE = {3'b111, 10'd0};
  localparam logic [12:0] CLR = {3'b011, 10'd0};
  localparam logic [12:0] STA = {3'b110, 10'd0};
  always #5 clock = ~clock;
  assign out = {clearn, stopn, startn, keypad};
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[4*r+c] && !row_n[r]) col_n[c] = 1'b0;
  end
  keypad_matrix_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_PASSES(3)) dut (
    .clock(clock),
    .resetn(resetn),
    .col_n(col_n),
    .row_n(row_n),
    .keypad(keypad),
    .startn(startn),
    .stopn(stopn),
    .clearn(clearn)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_out(input string tag, input logic [12:0] exp, input int maxc);
    int n = 0;
    while (out !== exp && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, out, exp);
  endtask
  function automatic logic [12:0] digit(input int k);
    logic [9:0] v = 10'd1 << k;
    return {3'b111, v};
  endfunction
  initial begin
    held = 16'd1 << 5;
    step(2);
    chk("reset_rows", {9'd0, row_n}, 13'h00F);
    chk("reset_outs", out, IDLE);
    resetn = 1'b1;
    step(1);
    chk("row0_a", {9'd0, row_n}, 13'h00E);
    step(3);
    chk("row0_b", {9'd0, row_n}, 13'h00E);
    step(1);
    chk("row1", {9'd0, row_n}, 13'h00D);
    wait_out("key5_press", digit(5), 68);
    for (int i = 0; i < 3; i++) begin
      step(16);
      chk("key5_steady", out, digit(5));
    end
    held = '0;
    wait_out("key5_release", IDLE, 68);
    for (int i = 0; i < 12; i++) begin
      held = (i % 2 == 0) ? 16'd1 << 8 : 16'd0;
      step(16);
      chk("bounce7", out, IDLE);
    end
    held = (16'd1 << 0) | (16'd1 << 1);
    for (int i = 0; i < 6; i++) begin
      step(16);
      chk("multi12", out, IDLE);
    end
    held = 16'd1 << 0;
    wait_out("key1_after_multi", digit(1), 68);
    held = 16'd1 << 11;
    wait_out("clear_press", CLR, 68);
    held = 16'd1 << 3;
    begin
      int n = 0;
      while (out === CLR && n < 68) begin
        step(1);
        n++;
      end
    end
    chk("clear_to_start", out, STA);
    held = 16'd1 << 10;
    wait_out("key9_press", digit(9), 68);
    resetn = 1'b0;
    step(1);
    chk("midpress_reset_outs", out, IDLE);
    chk("midpress_reset_rows", {9'd0, row_n}, 13'h00F);
    resetn = 1'b1;
    wait_out("key9_after_reset", digit(9), 68);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
